// File: rtl/mesh_pkg.sv
// Shared packet-field widths, header layout, FIFO control states and the
// destination legality rule for mesh terminal transmitters.
package mesh_pkg;

  localparam int unsigned NXT_JMP_W = 8;
  localparam int unsigned ROW_W     = 4;
  localparam int unsigned COL_W     = 4;
  localparam int unsigned MODE_W    = 1;
  localparam int unsigned HDR_W     = NXT_JMP_W + ROW_W + COL_W + MODE_W;

  localparam logic [ROW_W+COL_W-1:0] BDCST = 8'hFF;

  typedef struct packed {
    logic [NXT_JMP_W-1:0] nxt_jmp;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     col;
    logic                 mode;
  } pkt_hdr_t;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fifo_state_t;

  // Only edge terminals (outside the router grid) or the broadcast code are legal.
  function automatic logic legal_dest(
    input logic [ROW_W-1:0]       row,
    input logic [COL_W-1:0]       col,
    input int unsigned            rows,
    input int unsigned            cols,
    input logic [ROW_W+COL_W-1:0] bdcst = BDCST
  );
    int unsigned rv;
    int unsigned cv;
    logic        side_edge;
    logic        top_bot_edge;
    rv           = 32'(row);
    cv           = 32'(col);
    side_edge    = (rv >= 1) && (rv <= rows) && ((cv == 0) || (cv == cols + 1));
    top_bot_edge = (cv >= 1) && (cv <= cols) && ((rv == 0) || (rv == rows + 1));
    return side_edge || top_bot_edge || ({row, col} == bdcst);
  endfunction

endpackage

// File: rtl/term_fifo.sv
// Generic show-ahead synchronous FIFO; the head entry is visible on o_rd_data
// without a read request and is removed by i_pop.
module term_fifo
  import mesh_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  fifo_state_t      r_state;

  logic [CW-1:0]    w_count_nxt;
  fifo_state_t      w_state_nxt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_state == ST_FULL);
  assign o_empty   = (r_state == ST_EMPTY);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= ST_EMPTY;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Next occupancy and control state; the state mirrors the count boundaries.
  always_comb begin
    w_count_nxt = r_count;
    w_state_nxt = r_state;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_do_pop && !w_do_push) begin
      w_count_nxt = r_count - CW'(1);
    end
    case (r_state)
      ST_EMPTY: begin
        if (w_do_push) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_count_nxt == CW'(DEPTH)) begin
          w_state_nxt = ST_FULL;
        end else if (w_count_nxt == '0) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_do_pop) w_state_nxt = ST_ACTIVE;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

endmodule

// File: rtl/mesh_term_tx.sv
// Terminal-side transmitter: assembles client requests into mesh packets,
// queues them and hands them to the router input port on popin.
module mesh_term_tx
  import mesh_pkg::pkt_hdr_t;
  import mesh_pkg::legal_dest;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMNS    = 4,
  parameter int unsigned PAKG_SIZE  = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  BDCST      = mesh_pkg::BDCST
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [3:0]                    req_row,
  input  logic [3:0]                    req_col,
  input  logic                          req_mode,
  input  logic [PAKG_SIZE-18:0]         req_payload,
  output logic                          pndng_i_in,
  output logic [PAKG_SIZE-1:0]          data_out_i_in,
  input  logic                          popin,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   sent_cnt,
  output logic                          bad_dest,
  output logic                          spurious_pop
);

  pkt_hdr_t               w_hdr;
  logic [PAKG_SIZE-1:0]   w_pkt;
  logic [PAKG_SIZE-1:0]   w_head;
  logic                   w_legal;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;

  logic [15:0]            r_sent_cnt;
  logic                   r_bad_dest;
  logic                   r_spurious_pop;

  always_comb begin
    w_hdr         = '0;
    w_hdr.nxt_jmp = 8'h00;
    w_hdr.row     = req_row;
    w_hdr.col     = req_col;
    w_hdr.mode    = req_mode;
  end

  assign w_pkt    = {w_hdr, req_payload};
  assign w_legal  = legal_dest(req_row, req_col, ROWS, COLUMNS, BDCST);
  assign w_accept = req_valid & req_ready;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = popin & ~w_empty;

  term_fifo #(
    .WIDTH (PAKG_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_wr_data (w_pkt),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_count   (fifo_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Ready depends only on registered occupancy, never on popin.
  assign req_ready     = ~w_full;
  assign pndng_i_in    = ~w_empty;
  assign data_out_i_in = w_empty ? '0 : w_head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sent_cnt     <= '0;
      r_bad_dest     <= 1'b0;
      r_spurious_pop <= 1'b0;
    end else begin
      if (w_pop)                  r_sent_cnt     <= r_sent_cnt + 16'(1);
      if (w_accept && !w_legal)   r_bad_dest     <= 1'b1;
      if (popin && w_empty)       r_spurious_pop <= 1'b1;
    end
  end

  assign sent_cnt     = r_sent_cnt;
  assign bad_dest     = r_bad_dest;
  assign spurious_pop = r_spurious_pop;

endmodule

// File: tb/tb_mesh_term_tx.sv
// Randomized self-checking bench for mesh_term_tx against a queue-based
// reference model of the transmitter.
module tb_mesh_term_tx;

  localparam int unsigned PS    = 32;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_row;
  logic [3:0]    req_col;
  logic          req_mode;
  logic [14:0]   req_payload;
  logic          pndng_i_in;
  logic [31:0]   data_out_i_in;
  logic          popin;
  logic [4:0]    fifo_count;
  logic [15:0]   sent_cnt;
  logic          bad_dest;
  logic          spurious_pop;

  mesh_term_tx dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_row       (req_row),
    .req_col       (req_col),
    .req_mode      (req_mode),
    .req_payload   (req_payload),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .popin         (popin),
    .fifo_count    (fifo_count),
    .sent_cnt      (sent_cnt),
    .bad_dest      (bad_dest),
    .spurious_pop  (spurious_pop)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  int unsigned m_sent = 0;
  bit          m_bad  = 0;
  bit          m_spur = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_legal(input int row, input int col);
    if (row * 16 + col == 255) return 1;
    if (row >= 1 && row <= 4 && (col == 0 || col == 5)) return 1;
    if (col >= 1 && col <= 4 && (row == 0 || row == 5)) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] mk_pkt(input int row, input int col, input int mode, input int pld);
    return 32'((row << 20) + (col << 16) + (mode << 15) + (pld % 32768));
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".pndng"}, 64'(pndng_i_in), 64'(mq.size() != 0));
    chk({tag, ".data"},  64'(data_out_i_in), (mq.size() != 0) ? 64'(mq[0]) : 64'(0));
    chk({tag, ".count"}, 64'(fifo_count), 64'(mq.size()));
    chk({tag, ".ready"}, 64'(req_ready), 64'(mq.size() < DEPTH));
    chk({tag, ".sent"},  64'(sent_cnt), 64'(m_sent % 65536));
    chk({tag, ".bad"},   64'(bad_dest), 64'(m_bad));
    chk({tag, ".spur"},  64'(spurious_pop), 64'(m_spur));
  endtask

  // One clock: drive request/popin, let the edge happen, advance the model, compare.
  task automatic cycle(input string tag, input bit v, input int row, input int col,
                       input int mode, input int pld, input bit pop);
    bit accept;
    bit leg;
    bit do_pop;
    req_valid   = v;
    req_row     = 4'(row);
    req_col     = 4'(col);
    req_mode    = 1'(mode);
    req_payload = 15'(pld);
    popin       = pop;
    accept = v && (mq.size() < DEPTH);
    leg    = is_legal(row, col);
    do_pop = pop && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (pop && !do_pop) m_spur = 1;
    if (do_pop) begin
      void'(mq.pop_front());
      m_sent++;
    end
    if (accept && leg) mq.push_back(mk_pkt(row, col, mode, pld));
    if (accept && !leg) m_bad = 1;
    req_valid = 0;
    popin     = 0;
    check_all(tag);
  endtask

  task automatic rand_dest(output int row, output int col);
    case ($urandom_range(0, 4))
      0: begin row = $urandom_range(1, 4); col = 0; end
      1: begin row = $urandom_range(1, 4); col = 5; end
      2: begin col = $urandom_range(1, 4); row = 0; end
      3: begin col = $urandom_range(1, 4); row = 5; end
      default: begin row = 15; col = 15; end
    endcase
  endtask

  task automatic push_rand(input string tag, input bit pop);
    int row;
    int col;
    rand_dest(row, col);
    cycle(tag, 1, row, col, $urandom_range(0, 1), $urandom_range(0, 32767), pop);
  endtask

  task automatic model_reset();
    mq.delete();
    m_sent = 0;
    m_bad  = 0;
    m_spur = 0;
  endtask

  initial begin
    reset = 1; req_valid = 0; req_row = 0; req_col = 0; req_mode = 0;
    req_payload = 0; popin = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 0;

    // 1: single request, held until popin
    cycle("t1.acc", 1, 1, 0, 1, 16'hABCD, 0);
    chk("t1.pkt", 64'(data_out_i_in), 64'h0010_ABCD);
    cycle("t1.hold", 0, 0, 0, 0, 0, 0);
    cycle("t1.pop", 0, 0, 0, 0, 0, 1);
    chk("t1.sent", 64'(sent_cnt), 64'd1);

    // 2: fill to 16, 17th is held, then drain preserving order
    for (int i = 0; i < 16; i++) push_rand("t2.fill", 0);
    chk("t2.full", 64'(req_ready), 64'd0);
    push_rand("t2.held", 0);
    cycle("t2.pop1", 0, 0, 0, 0, 0, 1);
    push_rand("t2.17th", 0);
    for (int i = 0; i < 16; i++) cycle("t2.drain", 0, 0, 0, 0, 0, 1);

    // 3: push+pop every cycle at count 1
    push_rand("t3.seed", 0);
    begin
      int unsigned s0;
      s0 = m_sent;
      for (int i = 0; i < 100; i++) push_rand("t3.stream", 1);
      chk("t3.sent100", 64'(sent_cnt) - 64'(s0), 64'd100);
      chk("t3.count", 64'(fifo_count), 64'd1);
    end
    cycle("t3.drain", 0, 0, 0, 0, 0, 1);

    // 4: interior destination rejected, broadcast queued
    cycle("t4.interior", 1, 2, 2, 0, 15'h1234, 0);
    chk("t4.bad", 64'(bad_dest), 64'd1);
    cycle("t4.bcast", 1, 15, 15, 1, 15'h0F0F, 0);
    chk("t4.count", 64'(fifo_count), 64'd1);
    cycle("t4.drain", 0, 0, 0, 0, 0, 1);

    // 5: pop while empty
    cycle("t5.spur", 0, 0, 0, 0, 0, 1);
    chk("t5.flag", 64'(spurious_pop), 64'd1);

    // Random traffic, including illegal destinations
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3)
        cycle("rnd", $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 1), $urandom_range(0, 32767), $urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 1) == 1)
        push_rand("rnd", $urandom_range(0, 2) == 0);
      else
        cycle("rnd", 0, 0, 0, 0, 0, $urandom_range(0, 1));
    end
    while (mq.size() != 0) cycle("rnd.drain", 0, 0, 0, 0, 0, 1);

    // 6: asynchronous reset with packets queued
    for (int i = 0; i < 5; i++) push_rand("t6.fill", 0);
    cycle("t6.spur", 1, 2, 2, 0, 0, 0);
    #3;
    reset = 1;
    #1;
    model_reset();
    check_all("t6.async");
    @(posedge clk);
    #1;
    reset = 0;
    check_all("t6.rel");
    cycle("t6.req", 1, 0, 3, 0, 15'h5A5A, 0);
    chk("t6.pkt", 64'(data_out_i_in), 64'h0003_5A5A);
    cycle("t6.pop", 0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mesh_term_tx.md
Name: mesh_term_tx

Overview:
- Synthesizable terminal-side transmitter for one mesh_gnrtr input port.
- Accepts destination/mode/payload requests from a local client and assembles mesh packets.
- Buffers packets in a show-ahead FIFO and presents them on pndng_i_in/data_out_i_in.
- Releases each packet when the router pulses popin; this is the source end of the handshake the router's input port consumes.

Parameters:
- ROWS, 4, mesh rows; sets the valid destination range.
- COLUMNS, 4, mesh columns; sets the valid destination range.
- PAKG_SIZE, 32, packet width in bits; minimum 18.
- FIFO_DEPTH, 16, packet slots; must be a power of 2, minimum 2.
- BDCST, 8'hFF, {row,col} value that marks broadcast.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  client request accepted when high together with req_valid.
- req_row  in  4  destination row.
- req_col  in  4  destination column.
- req_mode  in  1  routing mode bit, passed through unchanged.
- req_payload  in  PAKG_SIZE-17  payload.
- pndng_i_in  out  1  packet pending toward the router.
- data_out_i_in  out  PAKG_SIZE  head packet.
- popin  in  1  router consumed the head packet.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- sent_cnt  out  16  packets popped; wraps modulo 2^16.
- bad_dest  out  1  sticky: a request had an illegal destination.
- spurious_pop  out  1  sticky: popin arrived while the FIFO was empty.

Behaviour:
- Packet format, MSB to LSB: nxt_jmp[8]=8'h00, row[4], col[4], mode[1], payload[PAKG_SIZE-17].
- Legal destinations (edge terminals only):
  - row in 1..ROWS with col 0 or COLUMNS+1; or
  - col in 1..COLUMNS with row 0 or ROWS+1; or
  - {row,col} == BDCST.
- req_ready = (fifo_count < FIFO_DEPTH). It is combinational from registered count only; there is no path from popin.
- Handshake req_valid & req_ready:
  - legal destination: packet is written at that edge;
  - illegal destination: request is consumed, nothing is written, bad_dest is set.
- Latency: a packet accepted at edge t gives pndng_i_in=1 with that packet on data_out_i_in after edge t, when the FIFO was empty before. One cycle, no bypass.
- pndng_i_in = (fifo_count != 0).
- data_out_i_in shows the head entry while pending and is all-zero while empty. It is stable until the pop.
- popin sampled high with pndng_i_in=1: head is removed at that edge, the next entry appears after the edge, and sent_cnt increments.
  - popin high for N cycles pops N packets; the router is expected to pulse it.
- popin while empty: ignored, spurious_pop is set, count stays 0 (no underflow).
- Simultaneous push and pop (not full): count is unchanged, pointers both advance, ordering is preserved.
  - With count==1, the new packet appears after the edge.
- Full with popin in the same cycle: req_ready is already 0, so only the pop happens.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Reset (any time, asynchronous assert):
  - count, pointers, sent_cnt and both sticky flags clear to 0;
  - pndng_i_in=0, data_out_i_in=0, req_ready=1;
  - in-flight packets are discarded;
  - storage contents need not be cleared.
- Control state per cycle is {EMPTY, ACTIVE, FULL}, derived from count.
  - EMPTY→ACTIVE on push; ACTIVE→FULL at DEPTH; FULL→ACTIVE on pop; ACTIVE→EMPTY when the last entry is popped.

Decomposition:
- Package mesh_pkg: field widths/offsets (NXT_JMP_W=8, ROW_W=4, COL_W=4), BDCST, a packed struct for the packet header, and function legal_dest(row,col,ROWS,COLUMNS).
- Sub-module term_fifo: generic show-ahead synchronous FIFO with push, pop, count, full and empty.
- mesh_term_tx adds packet assembly, legality checking, counters and sticky flags.

Test Plan:
1. Reset release, single request row=1,col=0,mode=1,payload=0xABCD, no popin → pndng_i_in=1 one cycle after accept, data_out_i_in=32'h0010_ABCD|(1<<15), held until popin; after popin pndng=0, sent_cnt=1.
2. Push 16 legal packets with popin=0 → req_ready=0, fifo_count=16; 17th req_valid is held; one popin → req_ready=1 next cycle, FIFO order preserved for all 17.
3. Continuous push and popin every cycle for 100 cycles starting at count=1 → count stays 1, sent_cnt=100, pointers wrap, no reordering.
4. Request row=2,col=2 (interior) then {row,col}=8'hFF → first is consumed, bad_dest=1, not queued; broadcast is queued; fifo_count=1.
5. popin pulse while empty → spurious_pop=1, fifo_count=0, pndng_i_in=0.
6. Reset asserted mid-cycle with 5 packets queued → pndng_i_in=0 immediately (asynchronous), count=0 and sticky flags clear; new request after release is delivered normally.
